register_file_sb: RTL



---
 rtl/register_file_sb_if.sv | 31 +++
 rtl/register_file_sb.sv | 115 +++++++++++
 2 files changed

// File: rtl/register_file_sb_if.sv
// Operand-fetch bus between the decode stage (master) and the scoreboarded register file (slave).
// Carries read ports, producer issue, writeback and the hazard outputs.
interface register_file_sb_if #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 5,
  parameter int READ_PORTS = 2
);
  logic [READ_PORTS-1:0]       read_enable;
  logic [READ_PORTS*DEPTH-1:0] read_index;
  logic [READ_PORTS*WIDTH-1:0] read_data;
  logic [READ_PORTS-1:0]       read_ready;
  logic                        issue_enable;
  logic [DEPTH-1:0]            issue_index;
  logic                        write_enable;
  logic [DEPTH-1:0]            write_index;
  logic [WIDTH-1:0]            write_data;
  logic                        stall;
  logic [DEPTH:0]              pending_count;

  modport master (
    output read_enable, read_index, issue_enable, issue_index,
           write_enable, write_index, write_data,
    input  read_data, read_ready, stall, pending_count
  );

  modport slave (
    input  read_enable, read_index, issue_enable, issue_index,
           write_enable, write_index, write_data,
    output read_data, read_ready, stall, pending_count
  );
endinterface

// File: rtl/register_file_sb.sv
// Multi-port integer register file with per-register pending bits, writeback bypass,
// optional hardwired-zero x0 and a locally generated operand hazard stall.
module register_file_sb #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 5,
  parameter int READ_PORTS = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic              clk,
  input  logic              reset,
  register_file_sb_if.slave bus
);
  localparam int NUM_WORDS = 2 ** DEPTH;

  logic [WIDTH-1:0]            regs_q [NUM_WORDS];
  logic [NUM_WORDS-1:0]        pending_q;
  logic [NUM_WORDS-1:0]        pending_d;
  logic [DEPTH:0]              count_q;
  logic [DEPTH:0]              count_d;
  logic                        write_eff_s;
  logic                        issue_eff_s;
  logic                        inc_s;
  logic                        dec_s;
  logic [READ_PORTS*WIDTH-1:0] rd_data_s;
  logic [READ_PORTS-1:0]       rd_ready_s;
  logic                        stall_s;

  // Qualify writeback/issue strobes (x0 is inert when hardwired to zero)
  always_comb begin
    write_eff_s = bus.write_enable;
    issue_eff_s = bus.issue_enable;
    if ((ZERO_REG != 0) && (bus.write_index == {DEPTH{1'b0}})) begin
      write_eff_s = 1'b0;
    end else begin
      write_eff_s = bus.write_enable;
    end
    if ((ZERO_REG != 0) && (bus.issue_index == {DEPTH{1'b0}})) begin
      issue_eff_s = 1'b0;
    end else begin
      issue_eff_s = bus.issue_enable;
    end
  end

  // Next pending vector and incremental popcount; a same-index issue beats the release
  always_comb begin
    pending_d = pending_q;
    if (write_eff_s) begin
      pending_d[bus.write_index] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (issue_eff_s) begin
      pending_d[bus.issue_index] = 1'b1;
    end else begin
      pending_d = pending_d;
    end
    inc_s   = issue_eff_s && !pending_q[bus.issue_index];
    dec_s   = write_eff_s && pending_q[bus.write_index] &&
              !(issue_eff_s && (bus.issue_index == bus.write_index));
    count_d = count_q + {{DEPTH{1'b0}}, inc_s} - {{DEPTH{1'b0}}, dec_s};
  end

  // Register array storage; reset dominates any concurrent writeback
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        regs_q[i] <= {WIDTH{1'b0}};
      end
    end else if (write_eff_s) begin
      regs_q[bus.write_index] <= bus.write_data;
    end
  end

  // Scoreboard state: pending bits and their count
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= {NUM_WORDS{1'b0}};
      count_q   <= {(DEPTH + 1){1'b0}};
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  // Combinational read ports with writeback forwarding and hazard stall
  always_comb begin
    rd_data_s  = {(READ_PORTS * WIDTH){1'b0}};
    rd_ready_s = {READ_PORTS{1'b1}};
    stall_s    = 1'b0;
    for (int p = 0; p < READ_PORTS; p++) begin
      if (!bus.read_enable[p]) begin
        rd_data_s[p*WIDTH +: WIDTH] = {WIDTH{1'b0}};
        rd_ready_s[p]               = 1'b1;
      end else if ((ZERO_REG != 0) &&
                   (bus.read_index[p*DEPTH +: DEPTH] == {DEPTH{1'b0}})) begin
        rd_data_s[p*WIDTH +: WIDTH] = {WIDTH{1'b0}};
        rd_ready_s[p]               = 1'b1;
      end else if ((BYPASS != 0) && write_eff_s &&
                   (bus.write_index == bus.read_index[p*DEPTH +: DEPTH])) begin
        rd_data_s[p*WIDTH +: WIDTH] = bus.write_data;
        rd_ready_s[p]               = 1'b1;
      end else begin
        rd_data_s[p*WIDTH +: WIDTH] = regs_q[bus.read_index[p*DEPTH +: DEPTH]];
        rd_ready_s[p]               = !pending_q[bus.read_index[p*DEPTH +: DEPTH]];
      end
      stall_s = stall_s | (bus.read_enable[p] & ~rd_ready_s[p]);
    end
  end

  assign bus.read_data     = rd_data_s;
  assign bus.read_ready    = rd_ready_s;
  assign bus.stall         = stall_s;
  assign bus.pending_count = count_q;
endmodule
